// File: rtl/seg7_pkg.sv
// Glyph table and slot-to-digit mapping for the seven-segment scanner.
// Pure constants/functions; no timing or flow control involved.
package seg7_pkg;

    // Segment order a..g, active-low; seg[0] = a.
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Slot 0 is the leftmost digit, so scanning runs left to right.
    function automatic int digit_index(input int sel, input int num_digits);
        return num_digits - 1 - sel;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph, optional hex, forced blank.
// Latency: combinational. Backpressure: none.
// Codes 10..15 are blank unless hex_mode is set.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                4'd10:   seg = hex_mode ? SEG_A : SEG_BLANK;
                4'd11:   seg = hex_mode ? SEG_B : SEG_BLANK;
                4'd12:   seg = hex_mode ? SEG_C : SEG_BLANK;
                4'd13:   seg = hex_mode ? SEG_D : SEG_BLANK;
                4'd14:   seg = hex_mode ? SEG_E : SEG_BLANK;
                default: seg = hex_mode ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-seg driver: frame-latched inputs, LZ blank, blink, PWM, guard.
// Latency: outputs registered, 1 cycle after timer/sel/shadow state.
// Backpressure: none; free-running scan, inputs sampled once per frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 16,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int TW  = $clog2(REFRESH_DIV);
    localparam int SW  = $clog2(NUM_DIGITS);
    localparam int BFW = $clog2(BLINK_FRAMES + 1);

    localparam logic [TW-1:0]  T_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0]  T_GUARD = TW'(GUARD);
    localparam logic [SW-1:0]  S_LAST  = SW'(NUM_DIGITS - 1);
    localparam logic [BFW-1:0] BF_LAST = BFW'(BLINK_FRAMES);

    logic [TW-1:0]           timer;
    logic [SW-1:0]           sel;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [BFW-1:0]          frame_cnt;
    logic                    blink_on;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_hex;
    logic                    sh_lz;
    logic [PWM_BITS-1:0]     sh_bright;

    logic                    latch;
    logic [SW-1:0]           idx;
    logic [3:0]              nib;
    logic                    dp_req;
    logic                    blink_req;
    logic                    lz_hit;
    logic                    blank;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lzb;
    logic                    an_en;
    logic [NUM_DIGITS-1:0]   an_c;
    logic                    dp_c;
    logic [0:6]              seg_c;

    assign latch = (timer == '0) && (sel == '0);
    assign an_en = (timer >= T_GUARD) && ((pwm_cnt < sh_bright) || (&sh_bright));

    always_comb begin
        idx       = SW'(digit_index(int'(sel), NUM_DIGITS));
        nib       = 4'd0;
        dp_req    = 1'b0;
        blink_req = 1'b0;
        lz_hit    = 1'b0;
        an_c      = '1;
        zero_run  = 1'b1;
        lzb       = '0;
        // Zero run from the left; digit 0 is excluded so a value of 0 still shows.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (sh_digits[4*i +: 4] == 4'd0);
            lzb[i]   = sh_lz & zero_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == SW'(i)) begin
                nib       = sh_digits[4*i +: 4];
                dp_req    = sh_dp[i];
                blink_req = sh_blink[i];
                lz_hit    = lzb[i];
                an_c[i]   = ~an_en;
            end
        end
        blank = lz_hit | (blink_req & ~blink_on);
        dp_c  = ~(dp_req & ~blank);
    end

    seg7_decode u_decode (
        .nibble   (nib),
        .hex_mode (sh_hex),
        .blank    (blank),
        .seg      (seg_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            sel        <= '0;
            pwm_cnt    <= '0;
            frame_cnt  <= '0;
            blink_on   <= 1'b1;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            sh_hex     <= 1'b0;
            sh_lz      <= 1'b0;
            sh_bright  <= '0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (timer == T_LAST) begin
                timer <= '0;
                sel   <= (sel == S_LAST) ? '0 : sel + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end

            if (latch) begin
                sh_digits <= digits;
                sh_dp     <= dp_in;
                sh_blink  <= blink_mask;
                sh_hex    <= hex_mode;
                sh_lz     <= lz_blank;
                sh_bright <= brightness;
                // Counter restarts at 1 so each phase spans exactly BLINK_FRAMES frames.
                if (frame_cnt == BF_LAST) begin
                    blink_on  <= ~blink_on;
                    frame_cnt <= BFW'(1);
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            frame_done <= latch;
            seg        <= seg_c;
            dp         <= dp_c;
            an         <= an_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed frame-by-frame bench for seg7_scan_driver (4 digits, 8-cycle slots, guard 2).
// Outputs are sampled on the falling edge; expected glyphs are hand-derived per slot.
module tb_seg7_scan_driver;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        hex_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic [1:0]  brightness = '0;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .GUARD        (2),
        .PWM_BITS     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for frame_done (must come one cycle later), then checks all 32 cycles of the frame.
    // exp_seg holds the slot glyphs left to right; exp_dp the slot dp levels left to right.
    task automatic do_frame(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                            input int br, input bit mid_chg, input logic [15:0] mid_val);
        int         waited = 0;
        int         s;
        int         t;
        logic [3:0] exp_an;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame_done && waited < 40);
        check({tag, " fd_wait"}, waited, 1);
        check({tag, " k0 an"}, 32'(an), 32'hF);
        check({tag, " k0 fd"}, 32'(frame_done), 1);
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            if (mid_chg && k == 10) digits = mid_val;
            s = k / 8;
            t = k % 8;
            exp_an = 4'hF;
            if (t >= 2 && ((t % 4) < br || br == 3)) exp_an[3-s] = 1'b0;
            check($sformatf("%s k%0d an", tag, k), 32'(an), 32'(exp_an));
            check($sformatf("%s k%0d seg", tag, k), 32'(seg), 32'(exp_seg[27-7*s -: 7]));
            check($sformatf("%s k%0d dp", tag, k), 32'(dp), 32'(exp_dp[3-s]));
            check($sformatf("%s k%0d fd", tag, k), 32'(frame_done), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst an", 32'(an), 32'hF);
        check("rst seg", 32'(seg), 32'(BL));
        check("rst dp", 32'(dp), 1);
        check("rst fd", 32'(frame_done), 0);

        // Frames are numbered from reset; blink phase is off in frames 3,4,7,8.
        digits = 16'h1234; brightness = 2'd3;
        rst = 1'b0;
        do_frame("f1_1234", {G1, G2, G3, G4}, 4'b1111, 3, 1'b0, 16'h0);

        digits = 16'h00A5; lz_blank = 1'b1; dp_in = 4'b1001;
        do_frame("f2_lz_dec", {BL, BL, BL, G5}, 4'b1110, 3, 1'b0, 16'h0);

        hex_mode = 1'b1;
        do_frame("f3_lz_hex", {BL, BL, GA, G5}, 4'b1110, 3, 1'b0, 16'h0);

        digits = 16'h0000; dp_in = 4'b0000;
        do_frame("f4_zero", {BL, BL, BL, G0}, 4'b1111, 3, 1'b0, 16'h0);

        digits = 16'h1234; lz_blank = 1'b0; hex_mode = 1'b0; brightness = 2'd1;
        do_frame("f5_br1", {G1, G2, G3, G4}, 4'b1111, 1, 1'b0, 16'h0);

        brightness = 2'd0;
        do_frame("f6_br0", {G1, G2, G3, G4}, 4'b1111, 0, 1'b0, 16'h0);

        brightness = 2'd3; blink_mask = 4'b0001; dp_in = 4'b0001;
        do_frame("f7_blk_off", {G1, G2, G3, BL}, 4'b1111, 3, 1'b0, 16'h0);
        do_frame("f8_blk_off", {G1, G2, G3, BL}, 4'b1111, 3, 1'b0, 16'h0);
        do_frame("f9_blk_on", {G1, G2, G3, G4}, 4'b1110, 3, 1'b0, 16'h0);
        do_frame("f10_blk_on", {G1, G2, G3, G4}, 4'b1110, 3, 1'b0, 16'h0);

        blink_mask = 4'b0000; dp_in = 4'b0000; digits = 16'h1111;
        do_frame("f11_mid", {G1, G1, G1, G1}, 4'b1111, 3, 1'b1, 16'h2222);
        do_frame("f12_new", {G2, G2, G2, G2}, 4'b1111, 3, 1'b0, 16'h0);

        // Reset in the middle of slot 1 (t=4 there, anode 2 lit).
        repeat (13) @(negedge clk);
        check("pre_rst an", 32'(an), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst an", 32'(an), 32'hF);
        check("mid_rst seg", 32'(seg), 32'(BL));
        check("mid_rst dp", 32'(dp), 1);
        check("mid_rst fd", 32'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
        do_frame("post_rst", {G2, G2, G2, G2}, 4'b1111, 3, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver, the successor to the 4-digit BCD scanner used for the game's time and score readouts. Drives NUM_DIGITS common-anode digits from a packed nibble bus. Adds the following over the previous scanner:
- hex or decimal decode,
- leading-zero blanking,
- per-digit decimal points and blinking,
- PWM brightness,
- an inter-digit anti-ghost guard,
- tear-free frame latching of all inputs.

## Interface
- NUM_DIGITS, 4: digits scanned, 2..8.
- REFRESH_DIV, 100000: clk cycles per digit slot; must exceed GUARD.
- GUARD, 16: cycles at the start of each slot with all anodes off; must be at least 1.
- PWM_BITS, 4: brightness resolution.
- BLINK_FRAMES, 128: frames per blink half-period.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  packed nibbles; [4*NUM_DIGITS-1 -: 4] is the leftmost digit.
- dp_in  in  NUM_DIGITS  decimal-point request, bit i pairs with nibble i; 1 = lit.
- blink_mask  in  NUM_DIGITS  1 = digit i blinks.
- hex_mode  in  1  1 = codes 10..15 render as A b C d E F.
- lz_blank  in  1  1 = blank leading zeros.
- brightness  in  PWM_BITS  0 = dark; all-ones = full on.
- seg  out  [0:6]  segments a..g, active-low; seg[0] = a.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low; an[NUM_DIGITS-1] = leftmost digit.
- frame_done  out  1  one-cycle pulse when a new frame is latched.

## Operation

Slot timing:
- timer counts 0..REFRESH_DIV-1.
- At the terminal count, timer returns to 0 and sel advances.
- sel wraps from NUM_DIGITS-1 to 0.
- Slot sel shows nibble NUM_DIGITS-1-sel on anode an[NUM_DIGITS-1-sel], so scanning runs left to right.

Frame latch:
- On every cycle with timer==0 and sel==0, copy digits, dp_in, blink_mask, hex_mode, lz_blank and brightness into shadow registers.
- All decoding uses shadow values only.
- Input changes mid-frame are invisible until the next frame.

Decode (segment order a..g, active-low):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Codes 10..15 with hex_mode=0 render blank (1111111).

Leading-zero blanking:
- When lz_blank=1, zeros from the left are blanked up to the first nonzero nibble.
- The rightmost digit is never blanked by this rule.
- A blanked digit also suppresses its dp.

Blink:
- A frame counter toggles blink_phase every BLINK_FRAMES frames.
- blink_phase resets to "on".
- While blink_phase is "off", digits with a shadow blink_mask bit of 1 show blank segments and dp off. Their anode timing is unchanged.

PWM:
- pwm_cnt is free-running, PWM_BITS wide, and increments every clk.
- The anode is enabled only when timer>=GUARD and (pwm_cnt<brightness or brightness is all-ones).

## Timing
- seg, dp, an and frame_done are registered: 1-cycle latency from the timer/sel/shadow state.
- Reset values:
  - seg 1111111, dp 1, an all ones, frame_done 0.
  - timer 0, sel 0, pwm_cnt 0, shadow registers 0, blink_phase on, frame counter 0.
- The first cycle after rst deasserts is a latch cycle. frame_done is high on the following cycle.
- On the latch cycle the outputs still use the old shadow. This is harmless because timer=0<GUARD, so all anodes are off.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. frame_done rises exactly once per frame.
- Reset mid-frame takes effect on the next edge: outputs return to reset values and scanning restarts at sel 0.
- If rst is asserted on a latch cycle, reset wins and nothing is latched.
- brightness changes take effect only at the next frame.

## Structure
- Package seg7_pkg holds:
  - the 16 glyph constants plus SEG_BLANK,
  - a function digit_index(sel) returning NUM_DIGITS-1-sel.
- Sub-module seg7_decode is combinational: nibble, hex_mode and blank → seg[0:6]. Instantiate it once on the muxed nibble.
- The top level holds the timer, sel, pwm_cnt, shadow, blink and leading-zero logic, and the output registers.

## Test plan
Bench parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, PWM_BITS=2, BLINK_FRAMES=2.

1. Reset, then digits=16'h1234, brightness=3 → first frame_done 1 cycle after release. Per slot, an sequence 0111, 1011, 1101, 1110 is active for 6 of 8 cycles. seg shows 1001111, 0010010, 0000110, 1001100.
2. digits=16'h00A5, hex_mode=0, lz_blank=1 → digits 3 and 2 blank. Digit 1 (A, decimal mode) is blank. Digit 0 shows 0100100. Setting hex_mode=1 shows 0001000 on digit 1 starting the next frame.
3. digits=16'h0000, lz_blank=1 → only the rightmost digit shows 0000001.
4. brightness=1 → within each active window the anode is low only when pwm_cnt==0. brightness=0 → an stays 1111 for the whole frame.
5. blink_mask=4'b0001 → digit 0 is blank for 2 frames, then lit for 2 frames. The other digits are unaffected.
6. Change digits mid-frame from 16'h1111 to 16'h2222 → slots already in progress still show 1 until the next frame_done. rst asserted mid-slot → next cycle an=1111, seg=1111111, sel=0.
